// File: rtl/pong_game_engine.sv
// pong_game_engine: single-clock pong core with tick enables, serve/play/game-over
// FSM, scoring and paddle control. Positions are active-area pixel coordinates.
// Optional build macro: PONG_RALLY_SPEEDUP_EN (paddle returns within a rally raise
// the effective ball speed level).
module pong_game_engine #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned PADDLE_W     = 10,
    parameter int unsigned PADDLE_H     = 50,
    parameter int unsigned BALL_SIZE    = 3,
    parameter int unsigned SPEED_LEVELS = 4,
    parameter int unsigned BASE_DIV     = 415000,
    parameter int unsigned DIV_STEP     = 55000,
    parameter int unsigned PADDLE_DIV   = 415000,
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_DELAY  = 60
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_game,
    input  logic [3:0]                      direction_switch,
    input  logic [$clog2(SPEED_LEVELS)-1:0] ball_speed,
    output logic [9:0]                      ball_x,
    output logic [9:0]                      ball_y,
    output logic [9:0]                      paddle1_y,
    output logic [9:0]                      paddle2_y,
    output logic [3:0]                      score1,
    output logic [3:0]                      score2,
    output logic                            game_over,
    output logic                            winner,
    output logic                            ball_tick,
    output logic [1:0]                      state
);

    localparam int unsigned LW  = $clog2(SPEED_LEVELS);
    localparam int unsigned BCW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam int unsigned PCW = (PADDLE_DIV > 1) ? $clog2(PADDLE_DIV) : 1;
    localparam int unsigned SCW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [9:0]    X_CTR    = 10'(H_ACTIVE / 2);
    localparam logic [9:0]    Y_CTR    = 10'(V_ACTIVE / 2);
    localparam logic [9:0]    P_INIT   = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [9:0]    P_MAX    = 10'(V_ACTIVE - PADDLE_H);
    localparam logic [9:0]    Y_MAX    = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]    X_HIT_L  = 10'(PADDLE_W);
    localparam logic [9:0]    X_HIT_R  = 10'(H_ACTIVE - PADDLE_W - BALL_SIZE);
    localparam logic [9:0]    X_MISS_R = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [LW-1:0] LVL_MAX  = LW'(SPEED_LEVELS - 1);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SERVE    = 2'd1,
        S_PLAY     = 2'd2,
        S_GAMEOVER = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [9:0]     ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]     paddle1_q, paddle1_d, paddle2_q, paddle2_d;
    logic [3:0]     score1_q, score1_d, score2_q, score2_d;
    logic           game_over_q, game_over_d;
    logic           winner_q, winner_d;
    logic           dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic [SCW-1:0] serve_cnt_q, serve_cnt_d;
    logic           start_prev_q;
    logic [BCW-1:0] ball_cnt_q, ball_cnt_d;
    logic           ball_tick_q, ball_tick_d;
    logic [LW-1:0]  level_q, level_d;
    logic [PCW-1:0] pad_cnt_q, pad_cnt_d;
    logic           pad_tick_q, pad_tick_d;

    logic           start_rise_c;
    logic           play_tick_c;
    logic           hit_l_c, hit_r_c, miss_l_c, miss_r_c, flip_y_c;
    logic [LW-1:0]  spd_sat_c, eff_level_c;

    // Ball step period in clk cycles for a given speed level
    function automatic logic [31:0] div_of(input logic [LW-1:0] lvl);
        return 32'(BASE_DIV) - 32'(lvl) * 32'(DIV_STEP);
    endfunction

    assign start_rise_c = start_game & ~start_prev_q;
    assign play_tick_c  = (state_q == S_PLAY) && ball_tick_q;

    // Collision terms use the ball and paddle values registered before this cycle
    assign hit_l_c  = dx_neg_q && (ball_x_q == X_HIT_L)
                   && (({1'b0, ball_y_q} + 11'(BALL_SIZE)) > {1'b0, paddle1_q})
                   && ({1'b0, ball_y_q} < ({1'b0, paddle1_q} + 11'(PADDLE_H)));
    assign hit_r_c  = !dx_neg_q && (ball_x_q == X_HIT_R)
                   && (({1'b0, ball_y_q} + 11'(BALL_SIZE)) > {1'b0, paddle2_q})
                   && ({1'b0, ball_y_q} < ({1'b0, paddle2_q} + 11'(PADDLE_H)));
    assign miss_l_c = dx_neg_q && (ball_x_q == 10'd0);
    assign miss_r_c = !dx_neg_q && (ball_x_q == X_MISS_R);
    assign flip_y_c = (dy_neg_q && (ball_y_q == 10'd0)) || (!dy_neg_q && (ball_y_q == Y_MAX));

    // Out-of-range speed requests map to the fastest level
    assign spd_sat_c = (32'(ball_speed) > SPEED_LEVELS - 1) ? LVL_MAX : ball_speed;

`ifdef PONG_RALLY_SPEEDUP_EN
    logic [1:0]    hit_cnt_q, hit_cnt_d;
    logic [LW-1:0] bonus_q, bonus_d;
    logic [LW:0]   lvl_sum_c;

    // Every fourth return in a rally adds one bonus level; a point clears the rally
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        bonus_d   = bonus_q;
        if (play_tick_c) begin
            if (miss_l_c || miss_r_c) begin
                hit_cnt_d = 2'd0;
                bonus_d   = '0;
            end else if (hit_l_c || hit_r_c) begin
                hit_cnt_d = hit_cnt_q + 2'd1;
                if ((hit_cnt_q == 2'd3) && (bonus_q < LVL_MAX)) begin
                    bonus_d = bonus_q + LW'(1);
                end
            end
        end
    end

    // Rally bonus registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q <= 2'd0;
            bonus_q   <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            bonus_q   <= bonus_d;
        end
    end

    assign lvl_sum_c   = {1'b0, spd_sat_c} + {1'b0, bonus_q};
    assign eff_level_c = (lvl_sum_c > {1'b0, LVL_MAX}) ? LVL_MAX : lvl_sum_c[LW-1:0];
`else
    assign eff_level_c = spd_sat_c;
`endif

    // Ball tick divider; the level is resampled only when the counter wraps
    always_comb begin
        level_d    = level_q;
        ball_cnt_d = ball_cnt_q + BCW'(1);
        if (ball_tick_q) begin
            ball_cnt_d = '0;
            level_d    = eff_level_c;
        end
        ball_tick_d = (32'(ball_cnt_d) == (div_of(level_d) - 32'd1));
    end

    // Paddle tick divider, free running
    always_comb begin
        pad_cnt_d  = pad_tick_q ? '0 : pad_cnt_q + PCW'(1);
        pad_tick_d = (32'(pad_cnt_d) == (PADDLE_DIV - 1));
    end

    // Paddle motion: one pixel per paddle tick, clamped, frozen in game over
    always_comb begin
        paddle1_d = paddle1_q;
        paddle2_d = paddle2_q;
        if (pad_tick_q && (state_q != S_GAMEOVER)) begin
            if (direction_switch[0] && !direction_switch[1] && (paddle1_q > 10'd0)) begin
                paddle1_d = paddle1_q - 10'd1;
            end else if (direction_switch[1] && !direction_switch[0] && (paddle1_q < P_MAX)) begin
                paddle1_d = paddle1_q + 10'd1;
            end
            if (direction_switch[2] && !direction_switch[3] && (paddle2_q > 10'd0)) begin
                paddle2_d = paddle2_q - 10'd1;
            end else if (direction_switch[3] && !direction_switch[2] && (paddle2_q < P_MAX)) begin
                paddle2_d = paddle2_q + 10'd1;
            end
        end
    end

    // Game FSM next state, ball motion and scoring
    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        dx_neg_d    = dx_neg_q;
        dy_neg_d    = dy_neg_q;
        serve_cnt_d = serve_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise_c) begin
                    state_d     = S_SERVE;
                    dx_neg_d    = 1'b0;
                    dy_neg_d    = 1'b0;
                    serve_cnt_d = '0;
                end
            end
            S_SERVE: begin
                if (ball_tick_q) begin
                    if (serve_cnt_q == SCW'(SERVE_DELAY - 1)) begin
                        state_d     = S_PLAY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SCW'(1);
                    end
                end
            end
            S_PLAY: begin
                if (ball_tick_q) begin
                    if (miss_l_c) begin
                        score2_d = score2_q + 4'd1;
                        if (score2_d == WIN) begin
                            state_d  = S_GAMEOVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d  = S_SERVE;
                            dx_neg_d = 1'b1;
                            dy_neg_d = 1'b0;
                        end
                    end else if (miss_r_c) begin
                        score1_d = score1_q + 4'd1;
                        if (score1_d == WIN) begin
                            state_d  = S_GAMEOVER;
                            winner_d = 1'b0;
                        end else begin
                            state_d  = S_SERVE;
                            dx_neg_d = 1'b0;
                            dy_neg_d = 1'b0;
                        end
                    end else begin
                        if (hit_l_c) begin
                            dx_neg_d = 1'b0;
                        end else if (hit_r_c) begin
                            dx_neg_d = 1'b1;
                        end
                        if (flip_y_c) begin
                            dy_neg_d = ~dy_neg_q;
                        end
                        ball_x_d = dx_neg_d ? ball_x_q - 10'd1 : ball_x_q + 10'd1;
                        ball_y_d = dy_neg_d ? ball_y_q - 10'd1 : ball_y_q + 10'd1;
                    end
                end
            end
            S_GAMEOVER: begin
                if (start_rise_c) begin
                    state_d     = S_SERVE;
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    dx_neg_d    = 1'b0;
                    dy_neg_d    = 1'b0;
                    serve_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outside PLAY the ball is parked at the centre
        if (state_d != S_PLAY) begin
            ball_x_d = X_CTR;
            ball_y_d = Y_CTR;
        end
        game_over_d = (state_d == S_GAMEOVER);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ball_x_q     <= X_CTR;
            ball_y_q     <= Y_CTR;
            paddle1_q    <= P_INIT;
            paddle2_q    <= P_INIT;
            score1_q     <= 4'd0;
            score2_q     <= 4'd0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
            dx_neg_q     <= 1'b0;
            dy_neg_q     <= 1'b0;
            serve_cnt_q  <= '0;
            start_prev_q <= 1'b0;
            ball_cnt_q   <= '0;
            ball_tick_q  <= 1'b0;
            level_q      <= '0;
            pad_cnt_q    <= '0;
            pad_tick_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            paddle1_q    <= paddle1_d;
            paddle2_q    <= paddle2_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            dx_neg_q     <= dx_neg_d;
            dy_neg_q     <= dy_neg_d;
            serve_cnt_q  <= serve_cnt_d;
            start_prev_q <= start_game;
            ball_cnt_q   <= ball_cnt_d;
            ball_tick_q  <= ball_tick_d;
            level_q      <= level_d;
            pad_cnt_q    <= pad_cnt_d;
            pad_tick_q   <= pad_tick_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign paddle1_y = paddle1_q;
    assign paddle2_y = paddle2_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign ball_tick = ball_tick_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: directed checks of tick rates, paddles, bounces, scoring and game over.
module tb_pong_game_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_game;
    logic [3:0] direction_switch;
    logic [1:0] ball_speed;
    logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
    logic [3:0] score1, score2;
    logic       game_over, winner, ball_tick;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] spd;
        int         period;
        int         count12;
    } tick_vec_t;

    typedef struct {
        logic [3:0] dir;
        int         ticks;
        int         exp_p1;
        int         exp_p2;
    } pad_vec_t;

    tick_vec_t tv [4];
    pad_vec_t  pv [13];
    int        wrap_exp [5] = '{0, 0, 1, 1, 1};

    pong_game_engine #(
        .BASE_DIV   (4),
        .DIV_STEP   (1),
        .PADDLE_DIV (2),
        .SERVE_DELAY(2),
        .WIN_SCORE  (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_game      (start_game),
        .direction_switch(direction_switch),
        .ball_speed      (ball_speed),
        .ball_x          (ball_x),
        .ball_y          (ball_y),
        .paddle1_y       (paddle1_y),
        .paddle2_y       (paddle2_y),
        .score1          (score1),
        .score2          (score2),
        .game_over       (game_over),
        .winner          (winner),
        .ball_tick       (ball_tick),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(ball_x);
            1:       return int'(ball_y);
            2:       return int'(state);
            3:       return int'(game_over);
            default: return int'(ball_tick);
        endcase
    endfunction

    // Poll at negedges until the selected signal reaches val; a timeout is a failure
    task automatic wait_sig(input string name, input int sel, input int val, input int max_cyc);
        int n;
        n = 0;
        while (sig(sel) != val && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sig(sel) != val) begin
            failures++;
            $display("FAIL %s: timeout, got %0d expected %0d", name, sig(sel), val);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ball_x"}, int'(ball_x), 320);
        chk({tag, "_ball_y"}, int'(ball_y), 240);
        chk({tag, "_p1"}, int'(paddle1_y), 215);
        chk({tag, "_p2"}, int'(paddle2_y), 215);
        chk({tag, "_s1"}, int'(score1), 0);
        chk({tag, "_s2"}, int'(score2), 0);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_gameover"}, int'(game_over), 0);
        chk({tag, "_winner"}, int'(winner), 0);
        chk({tag, "_tick"}, int'(ball_tick), 0);
    endtask

    task automatic pulse_start();
        start_game = 1'b1;
        @(negedge clk);
        start_game = 1'b0;
    endtask

    initial begin
        int n, gap, cnt;

        tv[0] = '{2'd0, 4, 3};
        tv[1] = '{2'd1, 3, 4};
        tv[2] = '{2'd2, 2, 6};
        tv[3] = '{2'd3, 1, 12};

        pv[0]  = '{4'b0001, 10,  205, 215};
        pv[1]  = '{4'b0010, 4,   209, 215};
        pv[2]  = '{4'b0011, 20,  209, 215};
        pv[3]  = '{4'b0100, 15,  209, 200};
        pv[4]  = '{4'b1000, 5,   209, 205};
        pv[5]  = '{4'b1100, 7,   209, 205};
        pv[6]  = '{4'b0000, 9,   209, 205};
        pv[7]  = '{4'b0001, 300, 0,   205};
        pv[8]  = '{4'b0001, 5,   0,   205};
        pv[9]  = '{4'b1010, 300, 300, 430};
        pv[10] = '{4'b1010, 200, 430, 430};
        pv[11] = '{4'b0101, 30,  400, 400};
        pv[12] = '{4'b0001, 200, 200, 400};

        reset            = 1'b1;
        start_game       = 1'b0;
        direction_switch = 4'b0000;
        ball_speed       = 2'd0;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;

        // Ball tick period per requested speed level
        for (int i = 0; i < 4; i++) begin
            ball_speed = tv[i].spd;
            repeat (10) @(negedge clk);
            n = 0;
            while (ball_tick !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (ball_tick !== 1'b1 && gap < 20);
            chk("tick_period", gap, tv[i].period);
            cnt = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (ball_tick) cnt++;
            end
            chk("tick_count12", cnt, tv[i].count12);
        end

        // Speed change takes effect only after the current period wraps
        ball_speed = 2'd0;
        repeat (10) @(negedge clk);
        n = 0;
        while (ball_tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("wrap_pre", int'(ball_tick), 0);
        ball_speed = 2'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("wrap_seq", int'(ball_tick), wrap_exp[k]);
        end

        // Paddle motion and clamping in IDLE
        for (int i = 0; i < 13; i++) begin
            direction_switch = pv[i].dir;
            repeat (2 * pv[i].ticks) @(negedge clk);
            chk("pad_p1", int'(paddle1_y), pv[i].exp_p1);
            chk("pad_p2", int'(paddle2_y), pv[i].exp_p2);
        end
        direction_switch = 4'b0000;
        chk("idle_state", int'(state), 0);

        // Rally: right paddle return, floor/ceiling bounce, left paddle return
        pulse_start();
        chk("serve_state", int'(state), 1);
        wait_sig("to_play", 2, 2, 20);
        chk("play_x0", int'(ball_x), 320);
        chk("play_y0", int'(ball_y), 240);
        wait_sig("reach_right", 0, 627, 400);
        chk("right_y", int'(ball_y), 407);
        @(negedge clk);
        chk("rret_x", int'(ball_x), 626);
        chk("rret_y", int'(ball_y), 406);
        wait_sig("reach_y1", 1, 1, 500);
        chk("y1_x", int'(ball_x), 221);
        @(negedge clk);
        chk("wall_y0", int'(ball_y), 0);
        @(negedge clk);
        chk("wall_y1", int'(ball_y), 1);
        chk("wall_x", int'(ball_x), 219);
        wait_sig("reach_left", 0, 10, 400);
        chk("left_y", int'(ball_y), 210);
        @(negedge clk);
        chk("lret_x", int'(ball_x), 11);
        chk("lret_y", int'(ball_y), 211);
        @(negedge clk);
        chk("lret_x2", int'(ball_x), 12);
        chk("rally_state", int'(state), 2);
        chk("rally_s2", int'(score2), 0);

        // Asynchronous reset in the middle of play
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b1;

        // Position paddles for two left-side misses
        direction_switch = 4'b1001;
        repeat (2 * 185) @(negedge clk);
        direction_switch = 4'b0001;
        repeat (2 * 40) @(negedge clk);
        direction_switch = 4'b0000;
        chk("miss_p1", int'(paddle1_y), 0);
        chk("miss_p2", int'(paddle2_y), 400);

        pulse_start();
        wait_sig("to_play2", 2, 2, 20);
        wait_sig("reach_left2", 0, 10, 1200);
        chk("left2_y", int'(ball_y), 210);
        @(negedge clk);
        chk("no_return_x", int'(ball_x), 9);
        wait_sig("to_serve", 2, 1, 40);
        chk("pt1_s2", int'(score2), 1);
        chk("pt1_s1", int'(score1), 0);
        chk("pt1_x", int'(ball_x), 320);
        chk("pt1_y", int'(ball_y), 240);
        wait_sig("to_play3", 2, 2, 20);
        chk("serve_x", int'(ball_x), 320);
        @(negedge clk);
        chk("serve_left_x", int'(ball_x), 319);
        chk("serve_left_y", int'(ball_y), 241);

        // start_game in PLAY is ignored
        pulse_start();
        chk("ign_state", int'(state), 2);
        chk("ign_s2", int'(score2), 1);

        wait_sig("to_gameover", 3, 1, 1200);
        chk("go_s2", int'(score2), 2);
        chk("go_s1", int'(score1), 0);
        chk("go_winner", int'(winner), 1);
        chk("go_state", int'(state), 3);
        chk("go_x", int'(ball_x), 320);
        chk("go_y", int'(ball_y), 240);

        // Paddles and ball frozen in GAMEOVER
        direction_switch = 4'b0010;
        repeat (20) @(negedge clk);
        direction_switch = 4'b0000;
        chk("go_p1_frozen", int'(paddle1_y), 0);
        chk("go_x_frozen", int'(ball_x), 320);
        chk("go_state_hold", int'(state), 3);

        // Restart clears scores and serves again
        start_game = 1'b1;
        @(negedge clk);
        chk("restart_state", int'(state), 1);
        chk("restart_s1", int'(score1), 0);
        chk("restart_s2", int'(score2), 0);
        chk("restart_go", int'(game_over), 0);
        start_game = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
- Single-clock game-logic core for the two-player VGA pong/foosball design. It replaces the per-speed divided clocks and the fixed-rate ball with internal tick enables.
- Parametrised in screen size, object sizes, number of speed levels and win score.
- Owns the serve/play/game-over state machine and scoring, and publishes positions and scores in active-area pixel coordinates.
- Sits between the switch inputs and the image generator/score display; everything runs in the clk domain, with no derived clocks.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- PADDLE_W, 10, paddle width (px)
- PADDLE_H, 50, paddle height (px)
- BALL_SIZE, 3, ball side (px)
- SPEED_LEVELS, 4, number of ball speed levels (>=2)
- BASE_DIV, 415000, clk cycles per ball step at level 0
- DIV_STEP, 55000, cycles removed per speed level; BASE_DIV-(SPEED_LEVELS-1)*DIV_STEP must be >=1
- PADDLE_DIV, 415000, clk cycles per paddle step
- WIN_SCORE, 9, score that ends the game (<=15)
- SERVE_DELAY, 60, ball ticks the ball is held centred before a serve

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_game  in  1  level input; a rising edge is detected internally
- direction_switch  in  4  [0] P1 up, [1] P1 down, [2] P2 up, [3] P2 down
- ball_speed  in  $clog2(SPEED_LEVELS)  requested speed level
- ball_x  out  10  ball left edge
- ball_y  out  10  ball top edge
- paddle1_y  out  10  left paddle top edge
- paddle2_y  out  10  right paddle top edge
- score1  out  4  player 1 score
- score2  out  4  player 2 score
- game_over  out  1  high in GAMEOVER
- winner  out  1  0 = P1, 1 = P2; valid while game_over
- ball_tick  out  1  one-cycle pulse on every ball step
- state  out  2  IDLE=0, SERVE=1, PLAY=2, GAMEOVER=3

Behaviour:
- Reset (reset=0, async) puts every output to its reset value:
  - ball_x=H_ACTIVE/2, ball_y=V_ACTIVE/2
  - paddles=(V_ACTIVE-PADDLE_H)/2
  - scores=0, game_over=0, winner=0, ball_tick=0, state=IDLE
  - internal dx=+1, dy=+1, all counters 0
- Ball tick:
  - Counter runs 0..D-1, with D=BASE_DIV-level*DIV_STEP.
  - ball_tick=1 in the cycle the counter equals D-1; the counter then returns to 0.
  - level is sampled from ball_speed only on wrap.
  - Out-of-range ball_speed is treated as SPEED_LEVELS-1.
- Paddle tick: a free-running PADDLE_DIV counter, same rule as the ball tick.
- Paddles, on each paddle tick in any state except GAMEOVER:
  - up only: y-1; down only: y+1; both or neither: hold.
  - Clamp to 0..V_ACTIVE-PADDLE_H.
- Collision and scoring are evaluated on a ball tick in PLAY, using the paddle values registered before this cycle:
  - Vertical: if (dy<0 and y==0) or (dy>0 and y==V_ACTIVE-BALL_SIZE), flip dy before stepping.
  - Left paddle: dx<0, x==PADDLE_W, ball_y+BALL_SIZE>paddle1_y and ball_y<paddle1_y+PADDLE_H → dx=+1.
  - Right paddle: the mirror case, at x==H_ACTIVE-PADDLE_W-BALL_SIZE against paddle2_y.
  - Corner hits flip both dx and dy in the same tick.
  - Step: x+=dx, y+=dy.
  - Miss: dx<0 and x==0 → score2+1; dx>0 and x==H_ACTIVE-BALL_SIZE → score1+1. The ball does not step on a miss tick.
- FSM:
  - IDLE: ball centred. start_game rise → SERVE with dx=+1.
  - SERVE: ball centred; after SERVE_DELAY ball ticks → PLAY.
  - PLAY, on a point:
    - If the new score equals WIN_SCORE → GAMEOVER, with winner = scoring player.
    - Otherwise → SERVE, dx pointing toward the conceding player, dy=+1.
  - GAMEOVER: ball frozen at centre, game_over=1. start_game rise → scores cleared, SERVE, dx=+1.
- A start_game rise in SERVE or PLAY is ignored.
- Scores never exceed WIN_SCORE.

Optional Feature:
- Macro: PONG_RALLY_SPEEDUP_EN.
- Defined:
  - Every 4 paddle returns within one rally raise the effective level by 1, saturating at SPEED_LEVELS-1.
  - effective level = min(ball_speed + bonus, SPEED_LEVELS-1).
  - bonus and the hit count clear on each point and on reset.
- Undefined: the level comes from ball_speed alone; no hit counter is synthesised.

Test Plan:
All scenarios use BASE_DIV=4, DIV_STEP=1, PADDLE_DIV=2, SERVE_DELAY=2.
- Reset mid-PLAY: drop reset with ball at (100,50) → same cycle: ball (320,240), paddles 215, scores 0, state 0, ball_tick 0.
- Tick rate: ball_speed=0 → ball_tick every 4 clk. ball_speed=3 → ball_tick every clk, changing only after the counter wraps.
- Paddle clamp: direction_switch=4'b0001 held 300 paddle ticks → paddle1_y=0 and stays 0. 4'b0011 → paddle1_y unchanged.
- Wall bounce: PLAY, ball_y=1, dy=-1 → next tick ball_y=0, following tick ball_y=1.
- Paddle return vs miss:
  - paddle1_y=215, ball at x=10, y=240, dx=-1 → dx becomes +1, x=11.
  - Same with paddle1_y=0 → ball reaches x=0, score2=1, state=SERVE, ball at (320,240), then PLAY moving left.
- Game over: WIN_SCORE=2, P1 misses twice → score2=2, game_over=1, winner=1, state=3. start_game pulse → scores 0, state=SERVE.
